// File: rtl/qdecode_core.sv
// Quadrature encoder decoder: synchronises and glitch-filters A/B/index pins,
// then decodes Gray-code transitions into a wrapping position count.
module qdecode_core #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             locked,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             index,
  input  logic             clear,
  output logic [WIDTH-1:0] position,
  output logic             direction,
  output logic             step,
  output logic [WIDTH-1:0] index_pos,
  output logic             index_seen,
  output logic             error,
  output logic [7:0]       error_count
);

  localparam int CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int INIT_LEN = SYNC_STAGES + FILTER_LEN;
  localparam int INIT_W   = $clog2(INIT_LEN + 1);
  localparam logic [WIDTH-1:0] POS_ONE = WIDTH'(1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  // Channel order inside the packed arrays: 0 = A, 1 = B, 2 = index.
  logic                        rst;
  logic [2:0]                  raw;
  logic [2:0][SYNC_STAGES-1:0] sync_q;
  logic [2:0]                  sync_out;
  logic [2:0]                  filt_q;
  logic [2:0][CNT_W-1:0]       cnt_q;

  state_t            state_q;
  logic [INIT_W-1:0] init_cnt_q;
  logic [1:0]        prev_q;
  logic              idx_prev_q;
  logic [WIDTH-1:0]  position_q, position_d, pos_step;
  logic              direction_q, step_q, index_seen_q, error_q;
  logic [WIDTH-1:0]  index_pos_q;
  logic [7:0]        error_count_q;

  logic       run;
  logic [1:0] cur;
  logic       is_up, is_dn, is_err, idx_rise;

  assign rst = !reset_n || !locked;
  assign raw = {index, quad_b, quad_a};

  always_comb begin
    for (int c = 0; c < 3; c++) sync_out[c] = sync_q[c][SYNC_STAGES-1];
  end

  // During INIT the filters track the synchronisers directly so RUN starts
  // from a settled view of the pins instead of the reset zeros.
  always_ff @(posedge clock_in) begin
    if (rst) begin
      sync_q <= '0;
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], raw[c]};
        if (state_q == S_INIT) begin
          filt_q[c] <= sync_out[c];
          cnt_q[c]  <= '0;
        end else if (sync_out[c] == filt_q[c]) begin
          cnt_q[c] <= '0;
        end else if (cnt_q[c] == CNT_W'(FILTER_LEN - 1)) begin
          filt_q[c] <= sync_out[c];
          cnt_q[c]  <= '0;
        end else begin
          cnt_q[c] <= cnt_q[c] + CNT_W'(1);
        end
      end
    end
  end

  function automatic logic [1:0] gray_up(input logic [1:0] s);
    case (s)
      2'b00:   gray_up = 2'b01;
      2'b01:   gray_up = 2'b11;
      2'b11:   gray_up = 2'b10;
      default: gray_up = 2'b00;
    endcase
  endfunction

  always_comb begin
    run      = (state_q == S_RUN);
    cur      = {filt_q[0], filt_q[1]};
    is_up    = run && (cur == gray_up(prev_q));
    is_dn    = run && (prev_q == gray_up(cur));
    is_err   = run && ((cur ^ prev_q) == 2'b11);
    idx_rise = run && filt_q[2] && !idx_prev_q;
    pos_step = position_q;
    if (is_up) pos_step = position_q + POS_ONE;
    else if (is_dn) pos_step = position_q - POS_ONE;
    position_d = clear ? '0 : pos_step;
  end

  always_ff @(posedge clock_in) begin
    if (rst) begin
      state_q       <= S_INIT;
      init_cnt_q    <= '0;
      prev_q        <= '0;
      idx_prev_q    <= 1'b0;
      position_q    <= '0;
      direction_q   <= 1'b0;
      step_q        <= 1'b0;
      index_pos_q   <= '0;
      index_seen_q  <= 1'b0;
      error_q       <= 1'b0;
      error_count_q <= '0;
    end else begin
      position_q   <= position_d;
      step_q       <= is_up || is_dn;
      index_seen_q <= idx_rise;
      if (is_up || is_dn) direction_q <= is_up;
      if (idx_rise) index_pos_q <= position_d;
      if (clear) begin
        error_q       <= 1'b0;
        error_count_q <= '0;
      end else if (is_err) begin
        error_q <= 1'b1;
        if (error_count_q != 8'hFF) error_count_q <= error_count_q + 8'd1;
      end
      case (state_q)
        S_INIT: begin
          // prev takes the value the filters load this edge, so RUN never
          // sees a stale pair left over from reset.
          prev_q     <= {sync_out[0], sync_out[1]};
          idx_prev_q <= sync_out[2];
          if (init_cnt_q == INIT_W'(INIT_LEN - 1)) state_q <= S_RUN;
          else init_cnt_q <= init_cnt_q + INIT_W'(1);
        end
        default: begin
          prev_q     <= cur;
          idx_prev_q <= filt_q[2];
        end
      endcase
    end
  end

  assign position    = position_q;
  assign direction   = direction_q;
  assign step        = step_q;
  assign index_pos   = index_pos_q;
  assign index_seen  = index_seen_q;
  assign error       = error_q;
  assign error_count = error_count_q;

endmodule

// File: tb/tb_qdecode_core.sv
// Directed bench for qdecode_core: filter latency, direction, wrap, glitch
// rejection, error flagging, index capture, lock loss and clear priority.
module tb_qdecode_core;

  logic        clock_in = 1'b0;
  logic        reset_n, locked, quad_a, quad_b, index, clear;
  logic [15:0] position, index_pos;
  logic        direction, step, index_seen, error;
  logic [7:0]  error_count;

  int n_vec = 0;
  int n_err = 0;
  int step_cnt = 0;
  int idx_cnt = 0;
  int total_steps = 0;
  logic [15:0] exp_pos = '0;

  qdecode_core #(.WIDTH(16), .SYNC_STAGES(2), .FILTER_LEN(4)) dut (
    .clock_in(clock_in), .reset_n(reset_n), .locked(locked),
    .quad_a(quad_a), .quad_b(quad_b), .index(index), .clear(clear),
    .position(position), .direction(direction), .step(step),
    .index_pos(index_pos), .index_seen(index_seen), .error(error),
    .error_count(error_count)
  );

  always #5 clock_in = ~clock_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      if (step) step_cnt++;
      if (index_seen) idx_cnt++;
    end
  endtask

  // Drive one pin pair, expect exactly one step 7 edges later.
  task automatic move(input logic a, input logic b, input string tag);
    int lat;
    int steps;
    lat = 0;
    steps = 0;
    quad_a = a;
    quad_b = b;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (step) begin
        steps++;
        if (lat == 0) lat = k;
      end
    end
    total_steps += steps;
    chk({tag, " latency"}, lat, 7);
    chk({tag, " steps"}, steps, 1);
    chk({tag, " position"}, {16'h0, position}, {16'h0, exp_pos});
  endtask

  initial begin
    reset_n = 1'b0; locked = 1'b1; quad_a = 1'b0; quad_b = 1'b0;
    index = 1'b0; clear = 1'b0;
    repeat (3) tick();
    chk("rst position", {16'h0, position}, 32'h0);
    chk("rst direction", {31'h0, direction}, 32'h0);
    chk("rst step", {31'h0, step}, 32'h0);
    chk("rst index_pos", {16'h0, index_pos}, 32'h0);
    chk("rst index_seen", {31'h0, index_seen}, 32'h0);
    chk("rst error", {31'h0, error}, 32'h0);
    chk("rst error_count", {24'h0, error_count}, 32'h0);

    reset_n = 1'b1;
    repeat (10) tick();

    // Eight forward Gray steps.
    exp_pos = 16'd1; move(1'b0, 1'b1, "fwd1");
    exp_pos = 16'd2; move(1'b1, 1'b1, "fwd2");
    exp_pos = 16'd3; move(1'b1, 1'b0, "fwd3");
    exp_pos = 16'd4; move(1'b0, 1'b0, "fwd4");
    exp_pos = 16'd5; move(1'b0, 1'b1, "fwd5");
    exp_pos = 16'd6; move(1'b1, 1'b1, "fwd6");
    exp_pos = 16'd7; move(1'b1, 1'b0, "fwd7");
    exp_pos = 16'd8; move(1'b0, 1'b0, "fwd8");
    chk("fwd total steps", total_steps, 8);
    chk("fwd direction", {31'h0, direction}, 32'h1);

    // Wrap below zero, then back up.
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear position", {16'h0, position}, 32'h0);
    exp_pos = 16'hFFFF; move(1'b1, 1'b0, "rev wrap");
    chk("rev direction", {31'h0, direction}, 32'h0);
    exp_pos = 16'h0000; move(1'b0, 1'b0, "wrap up");
    exp_pos = 16'h0001; move(1'b0, 1'b1, "up1");
    chk("up direction", {31'h0, direction}, 32'h1);

    // Glitch rejection: 3-cycle pulse ignored, 4-cycle pulse passes both ways.
    step_cnt = 0;
    quad_a = 1'b1; run_cycles(3); quad_a = 1'b0; run_cycles(12);
    chk("glitch3 steps", step_cnt, 0);
    chk("glitch3 position", {16'h0, position}, 32'h1);
    step_cnt = 0;
    quad_a = 1'b1; run_cycles(4); quad_a = 1'b0; run_cycles(16);
    chk("pulse4 steps", step_cnt, 2);
    chk("pulse4 position", {16'h0, position}, 32'h1);
    chk("pulse4 direction", {31'h0, direction}, 32'h0);

    // Illegal double transition 00 -> 11.
    exp_pos = 16'd0; move(1'b0, 1'b0, "to00");
    step_cnt = 0;
    quad_a = 1'b1; quad_b = 1'b1; run_cycles(10);
    chk("err steps", step_cnt, 0);
    chk("err flag", {31'h0, error}, 32'h1);
    chk("err count", {24'h0, error_count}, 32'h1);
    chk("err position", {16'h0, position}, 32'h0);
    chk("err direction held", {31'h0, direction}, 32'h0);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("err clear flag", {31'h0, error}, 32'h0);
    chk("err clear count", {24'h0, error_count}, 32'h0);
    chk("err clear position", {16'h0, position}, 32'h0);

    // Count to 5 from pins 11, then index capture.
    exp_pos = 16'd1; move(1'b1, 1'b0, "cnt1");
    exp_pos = 16'd2; move(1'b0, 1'b0, "cnt2");
    exp_pos = 16'd3; move(1'b0, 1'b1, "cnt3");
    exp_pos = 16'd4; move(1'b1, 1'b1, "cnt4");
    exp_pos = 16'd5; move(1'b1, 1'b0, "cnt5");
    idx_cnt = 0;
    index = 1'b1; run_cycles(10); index = 1'b0; run_cycles(8);
    chk("index_seen pulses", idx_cnt, 1);
    chk("index_pos", {16'h0, index_pos}, 32'h5);

    // Lock loss for one cycle with pins moving to 11.
    quad_a = 1'b1; quad_b = 1'b1; locked = 1'b0;
    tick();
    locked = 1'b1;
    chk("unlock position", {16'h0, position}, 32'h0);
    chk("unlock direction", {31'h0, direction}, 32'h0);
    chk("unlock index_pos", {16'h0, index_pos}, 32'h0);
    chk("unlock error_count", {24'h0, error_count}, 32'h0);
    step_cnt = 0;
    run_cycles(20);
    chk("relock steps", step_cnt, 0);
    chk("relock error", {31'h0, error}, 32'h0);
    chk("relock position", {16'h0, position}, 32'h0);

    // Clear coincident with a forward step from position 3.
    exp_pos = 16'd1; move(1'b1, 1'b0, "pre1");
    exp_pos = 16'd2; move(1'b0, 1'b0, "pre2");
    exp_pos = 16'd3; move(1'b0, 1'b1, "pre3");
    quad_a = 1'b1;
    run_cycles(6);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr+step step", {31'h0, step}, 32'h1);
    chk("clr+step position", {16'h0, position}, 32'h0);
    chk("clr+step direction", {31'h0, direction}, 32'h1);
    tick();
    chk("clr+step step once", {31'h0, step}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
